uart_frame_packetizer: RTL
==========================

Name: uart_frame_packetizer

Overview:
Parametrised successor to the team's fixed 8N1 UART packetizer FSM. It pops one word from a registered-read FIFO and builds a UART frame with configurable data width, parity and stop bits. It then launches the frame to the UART transmitter and tracks the transmitter's busy handshake through to completion. It adds an enable gate, a busy-start timeout with a sticky error flag, and a sent-frame counter. It sits between the TX FIFO and the UART serializer.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = append a parity bit after the data
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2
TIMEOUT_CYC, 16, maximum cycles from launch to tx_busy rising; must be ≥2
CNT_W, 16, width of frames_sent
FRAME_W (localparam), 1+DATA_W+PARITY_EN+STOP_BITS

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
en  in  1  when low, no new frame is started; a frame already in flight completes
fifo_empty  in  1  FIFO holds no data
fifo_rd_en  out  1  one-cycle pop strobe
fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en
tx_ready  in  1  transmitter can accept a frame
tx_busy  in  1  transmitter is shifting a frame
tx_enable  out  1  one-cycle launch pulse
tx_data  out  FRAME_W  frame, LSB sent first
err_timeout  out  1  sticky: tx_busy did not rise within TIMEOUT_CYC cycles of launch
err_clr  in  1  clears err_timeout
frames_sent  out  CNT_W  count of completed frames; wraps at 2^CNT_W

Behaviour:
- Reset values: state=IDLE, fifo_rd_en=0, tx_enable=0, tx_data=all ones (idle line), err_timeout=0, frames_sent=0, timeout counter=0. Reset mid-frame aborts the frame with no pop, launch or count.
- Frame layout: bit0=0 (start); bits[DATA_W:1]=fifo_data (LSB first); if PARITY_EN, bit[DATA_W+1] = XOR of the data bits, inverted when PARITY_ODD; the top STOP_BITS bits=1.
- All outputs are registered or Moore-decoded from the registered state. No output depends combinationally on an input.
- States:
  - IDLE: go to POP when en && !fifo_empty && tx_ready; otherwise stay.
  - POP: fifo_rd_en=1 for exactly this cycle; always go to LOAD.
  - LOAD: capture fifo_data, register tx_data; go to LAUNCH.
  - LAUNCH: tx_enable=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1: go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1 with tx_busy still 0, set err_timeout and go to IDLE. The frame is dropped and not counted.
  - WAIT_DONE: on tx_busy=0, increment frames_sent and go to IDLE.
- Latency: conditions true in IDLE at cycle N gives fifo_rd_en at N+1 and tx_enable with valid tx_data at N+3. Minimum frame spacing = 5 cycles plus the transmitter's busy time.
- tx_data holds the last frame until the next LOAD; it is never rewritten mid-frame.
- en falling in POP/LOAD/LAUNCH/WAIT_*: the current frame completes normally. en is sampled only in IDLE.
- fifo_empty or tx_ready changing after IDLE: ignored until the next IDLE. At most one pop per frame, so the FIFO never underflows.
- err_clr: clears err_timeout. If err_clr and a new timeout event occur in the same cycle, set wins. err_timeout does not block operation.
- frames_sent wraps from all-ones to 0 silently.

Decomposition:
- Package uart_pkg: state enum (IDLE, POP, LOAD, LAUNCH, WAIT_BUSY, WAIT_DONE), START_BIT=0, STOP_BIT=1, and the FRAME_W computation as a constant function.
- Sub-module uart_frame_builder: purely combinational; inputs data, outputs the framed word with parity; same parameters. The FSM, counters and flags stay in the top module.

Test Plan:
- Defaults; FIFO holds 0xA5; tx_ready=1; tx_busy high for 10 cycles starting 2 cycles after launch → rd_en at N+1, tx_enable at N+3, tx_data=10'b1_10100101_0, frames_sent=1.
- PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, DATA_W=7; data 0x35 (four ones) → tx_data=11'b11_1_0110101_0 (parity=1).
- tx_busy never rises, TIMEOUT_CYC=16 → err_timeout=1 exactly 16 cycles after tx_enable; frames_sent unchanged; FSM back to IDLE. err_clr → flag=0.
- Set timeout and err_clr asserted in the same cycle → err_timeout=1.
- FIFO with 3 words, en dropped during the second frame's WAIT_DONE → second frame completes, third not popped, frames_sent=2. en=1 → third frame sent.
- rst asserted in WAIT_BUSY → next cycle all outputs at reset values; FIFO pop count unchanged; CNT_W=2 with 5 frames → frames_sent=1 (wrap).

Source files
------------

// File: rtl/uart_frame_packetizer_pkg.sv
// Shared types and constants for the UART frame packetizer.
// The frame width is derived from the data width, parity option and stop-bit count.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LOAD      = 3'd2,
    LAUNCH    = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_w(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_frame_packetizer_if.sv
// FIFO-side and transmitter-side handshake bundle of the packetizer.
// The master modport is the packetizer; the slave modport is the FIFO/serializer side.
interface uart_frame_packetizer_if #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 10
);
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [DATA_W-1:0]  fifo_data;
  logic               tx_ready;
  logic               tx_busy;
  logic               tx_enable;
  logic [FRAME_W-1:0] tx_data;

  modport master (
    input  fifo_empty, fifo_data, tx_ready, tx_busy,
    output fifo_rd_en, tx_enable, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready, tx_busy,
    input  fifo_rd_en, tx_enable, tx_data
  );
endinterface

// File: rtl/uart_frame_builder.sv
// Combinational UART framer: start bit, data LSB first, optional parity, stop bits.
module uart_frame_builder
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_W   = frame_w(DATA_W, PARITY_EN, STOP_BITS)
) (
  input  logic [DATA_W-1:0]  data_i,
  output logic [FRAME_W-1:0] frame_o
);

  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    parity_bit = (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Frame assembly; without parity, bit DATA_W+1 is the first stop bit
  always_comb begin
    frame_o             = {FRAME_W{STOP_BIT}};
    frame_o[0]          = START_BIT;
    frame_o[DATA_W:1]   = data_i;
    if (PARITY_EN != 0) begin
      frame_o[DATA_W+1] = parity_bit(data_i);
    end else begin
      frame_o[DATA_W+1] = STOP_BIT;
    end
  end

endmodule

// File: rtl/uart_frame_packetizer.sv
// Pops one FIFO word, frames it, launches it to the UART serializer and tracks busy.
// Adds an enable gate, a busy-start timeout with sticky error and a sent-frame counter.
module uart_frame_packetizer
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16,
  localparam int FRAME_W    = frame_w(DATA_W, PARITY_EN, STOP_BITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err_clr,
  output logic                     err_timeout,
  output logic [CNT_W-1:0]         frames_sent,
  uart_frame_packetizer_if.master  bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  // Compare before incrementing so the flag lands TIMEOUT_CYC cycles after the launch pulse
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

  state_e             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               rd_en_q, rd_en_d;
  logic               tx_en_q, tx_en_d;
  logic               err_q, err_d;
  logic [FRAME_W-1:0] tx_data_q, tx_data_d;
  logic [FRAME_W-1:0] frame_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_s;

  uart_frame_builder #(
    .DATA_W     (DATA_W),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD),
    .STOP_BITS  (STOP_BITS)
  ) u_builder (
    .data_i  (bus.fifo_data),
    .frame_o (frame_s)
  );

  // Next-state, datapath and strobe decode
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !bus.fifo_empty && bus.tx_ready) state_d = POP;
        else                                       state_d = IDLE;
      end
      POP:    state_d = LOAD;
      LOAD: begin
        tx_data_d = frame_s;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        to_cnt_d = {TO_W{1'b0}};
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == POP);
    tx_en_d = (state_d == LAUNCH);
    if (timeout_s)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      to_cnt_q  <= {TO_W{1'b0}};
      rd_en_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      err_q     <= 1'b0;
      tx_data_q <= {FRAME_W{1'b1}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      rd_en_q   <= rd_en_d;
      tx_en_q   <= tx_en_d;
      err_q     <= err_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tx_enable  = tx_en_q;
  assign bus.tx_data    = tx_data_q;
  assign err_timeout    = err_q;
  assign frames_sent    = cnt_q;

endmodule
